// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-requester memory port arbiter:
// FSM state encoding and requester index constants.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_DBG = 1'b1;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick. On a tie the requester that was not granted
// last time wins; otherwise whichever requester is asking wins.
module rr_arbiter2
  import mem_arb_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic gnt_vld,
  output logic gnt_idx
);

  // Combinational grant decision from the two requests and the last winner.
  always_comb begin
    gnt_vld = req0 | req1;
    gnt_idx = REQ_CPU;
    if (req0 && req1) begin
      gnt_idx = ~last;
    end else if (req1) begin
      gnt_idx = REQ_DBG;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between the CPU core (requester 0) and a
// loader/debug port (requester 1). Each transaction runs IDLE -> BUSY -> RESP:
// the winner's command is latched in IDLE, held on the memory port through
// BUSY, and answered with a one-cycle ack in RESP. A watchdog turns a memory
// that never answers into an error response after TIMEOUT busy cycles.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 15,
  parameter int TW      = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  output logic [DW-1:0] rdata0,
  output logic          ack0,
  output logic          err0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic [DW-1:0] rdata1,
  output logic          ack1,
  output logic          err1,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_adr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ready
);

  state_t        state;
  logic          idx_q;
  logic          we_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] data_q;
  logic          err_q;
  logic          last_q;
  logic [TW-1:0] cnt_q;

  logic          gnt_vld;
  logic          gnt_idx;
  logic          resp0;
  logic          resp1;

  rr_arbiter2 u_rr (
    .req0    (req0),
    .req1    (req1),
    .last    (last_q),
    .gnt_vld (gnt_vld),
    .gnt_idx (gnt_idx)
  );

  // Transaction FSM with command latches and busy-cycle watchdog.
  // last_q resets to the debug port so the CPU wins the first tie.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ST_IDLE;
      idx_q   <= REQ_CPU;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
      last_q  <= REQ_DBG;
      cnt_q   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (gnt_vld) begin
            idx_q   <= gnt_idx;
            we_q    <= gnt_idx ? we1 : we0;
            addr_q  <= gnt_idx ? addr1 : addr0;
            wdata_q <= gnt_idx ? wdata1 : wdata0;
            state   <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          // A ready memory beats the watchdog on the final permitted cycle.
          if (mem_ready) begin
            data_q <= we_q ? '0 : mem_rdata;
            err_q  <= 1'b0;
            state  <= ST_RESP;
          end else if (cnt_q == TW'(TIMEOUT - 1)) begin
            data_q <= '0;
            err_q  <= 1'b1;
            cnt_q  <= cnt_q + TW'(1);
            state  <= ST_RESP;
          end else begin
            cnt_q <= cnt_q + TW'(1);
          end
        end
        ST_RESP: begin
          last_q <= idx_q;
          cnt_q  <= '0;
          state  <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Memory side is decoded from state and the latched command only, so a
  // requester can never reach mem_* combinationally.
  assign mem_en    = (state == ST_BUSY);
  assign mem_we    = mem_en & we_q;
  assign mem_adr   = addr_q;
  assign mem_wdata = wdata_q;

  // Response side: only the granted requester sees ack/rdata/err in RESP.
  assign resp0  = (state == ST_RESP) && (idx_q == REQ_CPU);
  assign resp1  = (state == ST_RESP) && (idx_q == REQ_DBG);
  assign ack0   = resp0;
  assign ack1   = resp1;
  assign rdata0 = resp0 ? data_q : '0;
  assign rdata1 = resp1 ? data_q : '0;
  assign err0   = resp0 & err_q;
  assign err1   = resp1 & err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios followed by randomized
// transactions, each judged against a transaction-level reference model.
module tb_mem_port_arbiter;

  localparam int AW      = 32;
  localparam int DW      = 32;
  localparam int TIMEOUT = 15;
  localparam int TW      = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          req0, we0, req1, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic [DW-1:0] rdata0, rdata1;
  logic          ack0, err0, ack1, err1;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_adr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ready;

  int errors = 0;
  int checks = 0;

  // Reference model state: who was granted last (CPU wins the first tie).
  bit model_last = 1'b1;

  mem_port_arbiter #(
    .AW(AW), .DW(DW), .TIMEOUT(TIMEOUT), .TW(TW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req0      (req0),
    .we0       (we0),
    .addr0     (addr0),
    .wdata0    (wdata0),
    .rdata0    (rdata0),
    .ack0      (ack0),
    .err0      (err0),
    .req1      (req1),
    .we1       (we1),
    .addr1     (addr1),
    .wdata1    (wdata1),
    .rdata1    (rdata1),
    .ack1      (ack1),
    .err1      (err1),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_adr   (mem_adr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".mem_en"}, 64'(mem_en), 64'd0);
    check({tag, ".mem_we"}, 64'(mem_we), 64'd0);
    check({tag, ".mem_adr"}, 64'(mem_adr), 64'd0);
    check({tag, ".mem_wdata"}, 64'(mem_wdata), 64'd0);
    check({tag, ".ack"}, 64'({ack0, ack1}), 64'd0);
    check({tag, ".err"}, 64'({err0, err1}), 64'd0);
    check({tag, ".rdata"}, {rdata0, rdata1}, 64'd0);
  endtask

  // One complete transaction, entered in an IDLE cycle just after a rising
  // edge. waits = busy cycles with mem_ready low before the memory answers;
  // waits >= TIMEOUT means the memory never answers. drop releases the
  // requests after the first busy cycle; keep leaves them asserted afterwards.
  task automatic txn(input string tag, input bit q0, input bit q1,
                     input bit w0, input logic [31:0] a0, input logic [31:0] d0,
                     input bit w1, input logic [31:0] a1, input logic [31:0] d1,
                     input int waits, input logic [31:0] rd,
                     input bit drop, input bit keep);
    bit          win;
    bit          ewe;
    logic [31:0] ea, ed, edata;
    bit          eerr;
    int          nb;
    req0 = q0; we0 = w0; addr0 = a0; wdata0 = d0;
    req1 = q1; we1 = w1; addr1 = a1; wdata1 = d1;
    mem_ready = 1'b0;
    win  = (q0 && q1) ? !model_last : q1;
    ewe  = win ? w1 : w0;
    ea   = win ? a1 : a0;
    ed   = win ? d1 : d0;
    eerr = (waits >= TIMEOUT);
    nb   = eerr ? TIMEOUT : waits + 1;
    edata = (eerr || ewe) ? 32'd0 : rd;
    for (int i = 0; i < nb; i++) begin
      @(posedge clk); #1;
      check({tag, ".busy_en"}, 64'(mem_en), 64'd1);
      check({tag, ".busy_we"}, 64'(mem_we), 64'(ewe));
      check({tag, ".busy_adr"}, 64'(mem_adr), 64'(ea));
      check({tag, ".busy_wdata"}, 64'(mem_wdata), 64'(ed));
      check({tag, ".busy_noack"}, 64'({ack0, ack1}), 64'd0);
      mem_ready = (i == waits);
      mem_rdata = (i == waits) ? rd : $urandom;
      if (drop && i == 0) begin
        req0 = 1'b0;
        req1 = 1'b0;
      end
    end
    @(posedge clk); #1;
    mem_ready = 1'b0;
    mem_rdata = $urandom;
    check({tag, ".resp_en"}, 64'({mem_en, mem_we}), 64'd0);
    check({tag, ".ack"}, 64'({ack1, ack0}), win ? 64'd2 : 64'd1);
    check({tag, ".rdata_win"}, 64'(win ? rdata1 : rdata0), 64'(edata));
    check({tag, ".err_win"}, 64'(win ? err1 : err0), 64'(eerr));
    check({tag, ".other_quiet"}, 64'({win ? rdata0 : rdata1, win ? err0 : err1}), 64'd0);
    model_last = win;
    if (!keep) begin
      req0 = 1'b0;
      req1 = 1'b0;
    end
    @(posedge clk); #1;
    check({tag, ".idle_noack"}, 64'({ack0, ack1}), 64'd0);
    check({tag, ".idle_en"}, 64'(mem_en), 64'd0);
  endtask

  initial begin
    reset = 1'b0;
    req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
    req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
    mem_rdata = '0; mem_ready = 1'b0;

    // Reset state
    #12;
    check_all_zero("reset");
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;

    // Single read, zero-wait memory
    txn("read0", 1, 0, 0, 32'h100, 32'h0, 0, 32'h0, 32'h0, 0, 32'hDEADBEEF, 0, 0);

    // Write from debug port with two wait cycles
    txn("write1", 0, 1, 0, 32'h0, 32'h0, 1, 32'h20, 32'h12345678, 2, 32'hCAFEF00D, 0, 0);

    // Contention: both held high for four transactions, grants alternate
    for (int k = 0; k < 4; k++) begin
      txn($sformatf("contend%0d", k), 1, 1, 0, 32'h400 + 32'(k), 32'h0,
          0, 32'h800 + 32'(k), 32'h0, k, 32'h1000 + 32'(k), 0, (k != 3));
    end

    // Timeout then a normal transaction
    txn("timeout", 1, 0, 0, 32'h200, 32'h0, 0, 32'h0, 32'h0, TIMEOUT + 3, 32'hBADBAD00, 0, 0);
    txn("after_to", 1, 0, 0, 32'h204, 32'h0, 0, 32'h0, 32'h0, 1, 32'h55AA55AA, 0, 0);

    // Boundary: ready on exactly the last permitted busy cycle
    txn("boundary", 1, 0, 0, 32'h208, 32'h0, 0, 32'h0, 32'h0, TIMEOUT - 1, 32'hA5A5A5A5, 0, 0);

    // Request dropped mid-busy still completes
    txn("drop", 0, 1, 0, 32'h0, 32'h0, 0, 32'h30, 32'h0, 3, 32'h0BADF00D, 1, 0);

    // Reset mid-transaction
    req1 = 1'b1; we1 = 1'b1; addr1 = 32'h44; wdata1 = 32'h99;
    @(posedge clk); #1;
    check("rst_mid.en_before", 64'(mem_en), 64'd1);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    check_all_zero("rst_mid");
    req1 = 1'b0; we1 = 1'b0;
    model_last = 1'b1;
    @(posedge clk); #1;
    reset = 1'b1;
    check("rst_rel.noack", 64'({ack0, ack1}), 64'd0);
    txn("post_reset", 1, 0, 0, 32'h300, 32'h0, 0, 32'h0, 32'h0, 0, 32'h13579BDF, 0, 0);

    // Randomized transactions
    for (int k = 0; k < 30; k++) begin
      bit q0, q1;
      int pick;
      pick = $urandom_range(2, 0);
      q0 = (pick != 1);
      q1 = (pick != 0);
      txn($sformatf("rand%0d", k), q0, q1,
          1'($urandom_range(1, 0)), $urandom, $urandom,
          1'($urandom_range(1, 0)), $urandom, $urandom,
          int'($urandom_range(TIMEOUT + 2, 0)), $urandom,
          1'($urandom_range(3, 0) == 0), 1'($urandom_range(1, 0)));
    end

    req0 = 1'b0; req1 = 1'b0;
    @(posedge clk); #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Hard bound on simulation time.
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "simulation time limit reached");
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single 32-bit memory port of the multicycle RISC-V system between two requesters.
- Requester 0 is the CPU core: instruction fetch, load and store all go through one Adr/WriteData/MemWrite/ReadData path.
- Requester 1 is a program loader / debug port.
- Sequences each transaction as request, memory access, then response, with round-robin fairness and a timeout watchdog. It sits between the core's memory interface and the memory.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- TIMEOUT, 15, maximum BUSY cycles without mem_ready before an error response (must be ≥1).
- TW, 4, timeout counter width; must satisfy 2^TW > TIMEOUT.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req0  in  1  requester 0 (CPU) access request.
- we0  in  1  requester 0 write enable.
- addr0  in  AW  requester 0 address.
- wdata0  in  DW  requester 0 write data.
- rdata0  out  DW  requester 0 read data, valid while ack0=1.
- ack0  out  1  requester 0 one-cycle completion pulse.
- err0  out  1  requester 0 timeout flag, valid while ack0=1.
- req1, we1, addr1, wdata1, rdata1, ack1, err1  —  same as requester 0, for requester 1.
- mem_en  out  1  memory access active.
- mem_we  out  1  memory write.
- mem_adr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  memory read data, valid when mem_ready=1.
- mem_ready  in  1  memory completes the access this cycle.

Behaviour:
- Reset (reset=0, async):
  - state=IDLE; last-granted pointer=1, so requester 0 wins the first tie.
  - timeout counter=0; captured data=0.
  - All outputs 0.
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - If any req is high, latch the winner index, we, addr and wdata into registers, then go to BUSY.
  - Round-robin: if both req are high, grant the requester not granted last.
  - Otherwise grant whichever req is high.
  - No req: stay in IDLE.
- BUSY:
  - mem_en=1; mem_we, mem_adr and mem_wdata driven from the latched registers (stable for the whole access).
  - Each cycle with mem_ready=0 increments the counter.
  - mem_ready=1: capture mem_rdata (writes capture 0), err=0, go to RESP.
  - If the counter reaches TIMEOUT with mem_ready still 0: captured data=0, err=1, go to RESP.
  - If mem_ready=1 in the same cycle the counter reaches TIMEOUT, mem_ready wins and err=0.
- RESP:
  - ackN=1 for the granted requester only, for exactly one cycle.
  - rdataN = captured data; errN = error flag.
  - Update the last-granted pointer, clear the counter, go to IDLE.
  - Non-granted ack, rdata and err stay 0.
- Latency:
  - req sampled high in IDLE at edge k → mem_en high from cycle k+1.
  - mem_ready at edge m → ack high during cycle m+1.
  - Minimum: 3 cycles from req to ack, with zero-wait memory.
- Requester rules:
  - Hold req, we, addr and wdata stable until ack.
  - Dropping req while in BUSY does not abort the transaction; the ack is still issued.
  - The first new request is sampled in the IDLE cycle after RESP, so back-to-back transactions have no bubble beyond the RESP→IDLE cycle.
- Outputs are registered or decoded from state only; no combinational path from req to mem_*.
- Reset mid-transaction: everything returns to the reset state immediately; no ack is issued and mem_en drops asynchronously.
- In IDLE and RESP, mem_en=0 and mem_we=0.
- mem_adr and mem_wdata hold their last values (do-not-care).

Decomposition:
- Shared package mem_arb_pkg:
  - state encoding constants ST_IDLE=2'd0, ST_BUSY=2'd1, ST_RESP=2'd2;
  - requester index constants REQ_CPU=1'b0, REQ_DBG=1'b1.
- One natural sub-module: rr_arbiter2, the combinational two-way round-robin pick from req0, req1 and the last-granted pointer.
- The FSM, latches and watchdog stay in the top module.

Test Plan:
- Reset check: drive reset=0 mid-BUSY → all outputs 0 at once; after release, req0=1 alone gives mem_en in cycle 1 with no stale ack.
- Single read: req0=1, addr0=0x100, mem_ready=1 on the first BUSY cycle with mem_rdata=0xDEADBEEF → ack0=1, rdata0=0xDEADBEEF, err0=0, 3 cycles after req.
- Write: req1=1, we1=1, addr1=0x20, wdata1=0x12345678, mem_ready after 2 wait cycles → mem_we=1 with mem_adr=0x20 and mem_wdata=0x12345678 for 3 cycles; then ack1 pulse, err1=0.
- Contention: req0 and req1 held high for 4 transactions → grants alternate 0,1,0,1 and each ack is a single-cycle pulse.
- Timeout: req0=1 with mem_ready held 0 → after 15 BUSY cycles, ack0=1, err0=1, rdata0=0; next request proceeds normally.
- Boundary: mem_ready=1 on exactly the 15th wait cycle → err0=0 and rdata is the mem_rdata value.
